// File: rtl/mem_arbiter.sv
// Arbiter between the I-cache refill port and the D-cache read/write port for a shared
// block memory. Each grant becomes a burst of BEATS fixed-width beats on a per-beat memory port.
module mem_arbiter #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned BLOCK_BITS  = 64,
    parameter int unsigned BEAT_BITS   = 16,
    parameter int unsigned HOLD_CYCLES = 4,
    localparam int unsigned BEATS      = BLOCK_BITS / BEAT_BITS,
    localparam int unsigned BEAT_W     = $clog2(BEATS)
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 i_req,
    input  logic [ADDR_W-1:0]    i_addr,
    output logic                 i_ack,
    output logic                 i_rvalid,
    output logic [BEAT_BITS-1:0] i_rdata,
    input  logic [1:0]           d_req,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic [BEAT_BITS-1:0] d_wdata,
    output logic                 d_ack,
    output logic                 d_wready,
    output logic                 d_rvalid,
    output logic [BEAT_BITS-1:0] d_rdata,
    output logic [BEAT_W-1:0]    beat,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [ADDR_W:0]      mem_addr,
    output logic [BEAT_BITS-1:0] mem_wdata,
    input  logic [BEAT_BITS-1:0] mem_rdata,
    output logic                 illegal_req
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_I_READ  = 3'd1;
    localparam logic [2:0] S_D_WRITE = 3'd2;
    localparam logic [2:0] S_D_HOLD  = 3'd3;
    localparam logic [2:0] S_D_READ  = 3'd4;

    localparam logic [1:0] REQ_READ  = 2'd1;
    localparam logic [1:0] REQ_WRITE = 2'd2;
    localparam logic [1:0] REQ_ILL   = 2'd3;

    logic [2:0]        r_state;
    logic [BEAT_W-1:0] r_beat;
    logic [HOLD_W-1:0] r_hold;
    logic              r_last_d;
    logic [ADDR_W-1:0] r_i_addr;
    logic [ADDR_W-1:0] r_d_addr;
    logic              r_illegal;

    logic [2:0]        w_state_d;
    logic [BEAT_W-1:0] w_beat_d;
    logic [HOLD_W-1:0] w_hold_d;
    logic              w_last_d_d;
    logic [ADDR_W-1:0] w_i_addr_d;
    logic [ADDR_W-1:0] w_d_addr_d;
    logic              w_illegal_d;

    logic w_last_beat;
    logic w_d_valid;
    logic w_in_i;
    logic w_in_dw;
    logic w_in_dr;

    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
    assign w_d_valid   = (d_req == REQ_READ) || (d_req == REQ_WRITE);

    always_comb begin
        w_state_d   = r_state;
        w_beat_d    = r_beat;
        w_hold_d    = r_hold;
        w_last_d_d  = r_last_d;
        w_i_addr_d  = r_i_addr;
        w_d_addr_d  = r_d_addr;
        w_illegal_d = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_beat_d    = '0;
                w_hold_d    = '0;
                w_illegal_d = (d_req == REQ_ILL);
                // On a tie the side that did not own the last burst wins.
                if (i_req && (!w_d_valid || r_last_d)) begin
                    w_state_d  = S_I_READ;
                    w_i_addr_d = i_addr;
                    w_last_d_d = 1'b0;
                end else if (w_d_valid) begin
                    w_state_d  = (d_req == REQ_WRITE) ? S_D_WRITE : S_D_READ;
                    w_d_addr_d = d_addr;
                    w_last_d_d = 1'b1;
                end
            end
            S_I_READ, S_D_READ: begin
                w_beat_d = r_beat + 1'b1;
                if (w_last_beat) begin
                    w_state_d = S_IDLE;
                    w_beat_d  = '0;
                end
            end
            S_D_WRITE: begin
                w_beat_d = r_beat + 1'b1;
                if (w_last_beat) begin
                    w_state_d = S_D_HOLD;
                    w_beat_d  = '0;
                    w_hold_d  = '0;
                end
            end
            S_D_HOLD: begin
                // D keeps ownership so a write-then-fill pair cannot be split by I.
                if (d_req == REQ_READ) begin
                    w_state_d  = S_D_READ;
                    w_d_addr_d = d_addr;
                    w_beat_d   = '0;
                    w_hold_d   = '0;
                end else if (r_hold == HOLD_W'(HOLD_CYCLES - 1)) begin
                    w_state_d = S_IDLE;
                    w_hold_d  = '0;
                end else begin
                    w_hold_d = r_hold + 1'b1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_beat_d  = '0;
                w_hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state   <= S_IDLE;
            r_beat    <= '0;
            r_hold    <= '0;
            r_last_d  <= 1'b1;
            r_i_addr  <= '0;
            r_d_addr  <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_beat    <= w_beat_d;
            r_hold    <= w_hold_d;
            r_last_d  <= w_last_d_d;
            r_i_addr  <= w_i_addr_d;
            r_d_addr  <= w_d_addr_d;
            r_illegal <= w_illegal_d;
        end
    end

    assign w_in_i  = (r_state == S_I_READ);
    assign w_in_dw = (r_state == S_D_WRITE);
    assign w_in_dr = (r_state == S_D_READ);

    always_comb begin
        i_ack       = w_in_i && (r_beat == '0);
        i_rvalid    = w_in_i;
        i_rdata     = w_in_i ? mem_rdata : '0;
        d_ack       = (w_in_dw || w_in_dr) && (r_beat == '0);
        d_wready    = w_in_dw;
        d_rvalid    = w_in_dr;
        d_rdata     = w_in_dr ? mem_rdata : '0;
        beat        = r_beat;
        mem_en      = w_in_i || w_in_dw || w_in_dr;
        mem_we      = w_in_dw;
        mem_wdata   = w_in_dw ? d_wdata : '0;
        illegal_req = r_illegal;
        mem_addr    = '0;
        if (w_in_i) begin
            mem_addr = {1'b0, r_i_addr};
        end else if (w_in_dw || w_in_dr) begin
            mem_addr = {1'b1, r_d_addr};
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues cycle-stamped expected output records,
// a negedge monitor compares every cycle in which the DUT shows any activity.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_ack;
    logic        i_rvalid;
    logic [15:0] i_rdata;
    logic [1:0]  d_req;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic        d_wready;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic [1:0]  beat;
    logic        mem_en;
    logic        mem_we;
    logic [16:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        illegal_req;

    mem_arbiter dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ack      (i_ack),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_wready   (d_wready),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .beat       (beat),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .illegal_req(illegal_req)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  flags;  // {illegal_req, d_rvalid, d_wready, i_rvalid}
        logic [1:0]  acks;   // {d_ack, i_ack}
        logic [1:0]  beat;
        logic        en;
        logic        we;
        logic [16:0] addr;
        logic [15:0] idata;
        logic [15:0] ddata;
        logic [15:0] wdata;
    } rec_t;

    rec_t        exp_q[$];
    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [31:0] cyc      = 0;
    logic [63:0] wbuf     = '0;
    logic [15:0] mem [0:524287];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: combinational read of (mem_addr, beat), write on the clock edge.
    assign mem_rdata = mem[{mem_addr, beat}];
    always @(posedge clk) if (mem_en === 1'b1 && mem_we === 1'b1) mem[{mem_addr, beat}] <= mem_wdata;

    // Cache-side write data is selected by the arbiter's beat index.
    assign d_wdata = wbuf[{beat, 4'b0000} +: 16];

    function automatic logic [15:0] pat(input logic [18:0] k);
        return k[15:0] ^ 16'h5A5A ^ {k[18:16], 13'h0};
    endfunction

    function automatic logic [63:0] pat4(input logic [16:0] a);
        logic [63:0] r;
        for (int b = 0; b < 4; b++) r[16*b +: 16] = pat({a, 2'(b)});
        return r;
    endfunction

    // kind: 0 I read, 1 D write, 2 D read
    task automatic exp_burst(input int kind, input logic [31:0] c0, input logic [16:0] a,
                             input logic [63:0] data, input int n);
        rec_t r;
        for (int b = 0; b < n; b++) begin
            r       = '0;
            r.cyc   = c0 + 32'(b);
            r.beat  = 2'(b);
            r.en    = 1'b1;
            r.we    = (kind == 1);
            r.addr  = a;
            r.flags = (kind == 0) ? 4'b0001 : (kind == 1) ? 4'b0010 : 4'b0100;
            if (b == 0) r.acks = (kind == 0) ? 2'b01 : 2'b10;
            if (kind == 0) r.idata = data[16*b +: 16];
            if (kind == 1) r.wdata = data[16*b +: 16];
            if (kind == 2) r.ddata = data[16*b +: 16];
            exp_q.push_back(r);
        end
    endtask

    task automatic exp_illegal(input logic [31:0] c0);
        rec_t r;
        r       = '0;
        r.cyc   = c0;
        r.flags = 4'b1000;
        exp_q.push_back(r);
    endtask

    always @(negedge clk) begin
        rec_t a;
        rec_t e;
        if ((i_ack | d_ack | i_rvalid | d_rvalid | d_wready | illegal_req | mem_en) === 1'b1) begin
            a = '{cyc: cyc, flags: {illegal_req, d_rvalid, d_wready, i_rvalid},
                  acks: {d_ack, i_ack}, beat: beat, en: mem_en, we: mem_we, addr: mem_addr,
                  idata: i_rdata, ddata: d_rdata, wdata: mem_wdata};
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_unexpected got=%h required=none", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard cyc=%0d got=%h required=%h", cyc, a, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input logic [31:0] t);
        while (cyc < t) step();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s got=%h required=%h", name, act, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c;
        logic [31:0] c2;
        for (int k = 0; k < 524288; k++) mem[k] = pat(19'(k));

        // Reset held with both sides requesting.
        n_rst  = 1'b0;
        i_req  = 1'b1;
        i_addr = 16'h0030;
        d_req  = 2'd1;
        d_addr = 16'h0031;
        repeat (3) step();
        chk("reset_i_ack", 32'(i_ack), 32'd0);
        chk("reset_d_ack", 32'(d_ack), 32'd0);
        chk("reset_mem_en", 32'(mem_en), 32'd0);
        chk("reset_beat", 32'(beat), 32'd0);
        c = cyc;
        exp_burst(0, c + 1, {1'b0, 16'h0030}, pat4({1'b0, 16'h0030}), 4);
        exp_burst(2, c + 6, {1'b1, 16'h0031}, pat4({1'b1, 16'h0031}), 4);
        n_rst = 1'b1;
        wait_until(c + 1);
        i_req = 1'b0;
        wait_until(c + 6);
        d_req = 2'd0;
        wait_until(c + 10);

        // Plain I refill; address changes after ack must not matter.
        c = cyc;
        i_addr = 16'h0012;
        i_req  = 1'b1;
        exp_burst(0, c + 1, {1'b0, 16'h0012}, pat4({1'b0, 16'h0012}), 4);
        wait_until(c + 1);
        i_req  = 1'b0;
        i_addr = 16'hFFFF;
        wait_until(c + 5);

        // Write, fill read from D_HOLD, I raised during hold served afterwards.
        c = cyc;
        wbuf   = 64'h00A3_00A2_00A1_00A0;
        d_addr = 16'h0005;
        d_req  = 2'd2;
        exp_burst(1, c + 1, {1'b1, 16'h0005}, 64'h00A3_00A2_00A1_00A0, 4);
        exp_burst(2, c + 7, {1'b1, 16'h0005}, 64'h00A3_00A2_00A1_00A0, 4);
        exp_burst(0, c + 12, {1'b0, 16'h0040}, pat4({1'b0, 16'h0040}), 4);
        wait_until(c + 1);
        d_req  = 2'd0;
        d_addr = 16'h1234;
        wait_until(c + 5);
        i_req  = 1'b1;
        i_addr = 16'h0040;
        wait_until(c + 6);
        chk("hold_no_mem_en", 32'(mem_en), 32'd0);
        d_req  = 2'd1;
        d_addr = 16'h0005;
        wait_until(c + 7);
        d_req = 2'd0;
        wait_until(c + 12);
        i_req = 1'b0;
        wait_until(c + 16);

        // Write with no fill: four hold cycles, then the pending I request.
        c = cyc;
        wbuf   = 64'h00B3_00B2_00B1_00B0;
        d_addr = 16'h0007;
        d_req  = 2'd2;
        exp_burst(1, c + 1, {1'b1, 16'h0007}, 64'h00B3_00B2_00B1_00B0, 4);
        exp_burst(0, c + 10, {1'b0, 16'h0050}, pat4({1'b0, 16'h0050}), 4);
        wait_until(c + 1);
        d_req = 2'd0;
        wait_until(c + 5);
        i_req  = 1'b1;
        i_addr = 16'h0050;
        wait_until(c + 9);
        chk("hold_expired_i_ack", 32'(i_ack), 32'd0);
        wait_until(c + 10);
        i_req = 1'b0;
        wait_until(c + 14);

        // Continuous requests from both: last owner was I, so D, I, D, I.
        c = cyc;
        i_req  = 1'b1;
        i_addr = 16'h0060;
        d_req  = 2'd1;
        d_addr = 16'h0005;
        exp_burst(2, c + 1, {1'b1, 16'h0005}, 64'h00A3_00A2_00A1_00A0, 4);
        exp_burst(0, c + 6, {1'b0, 16'h0060}, pat4({1'b0, 16'h0060}), 4);
        exp_burst(2, c + 11, {1'b1, 16'h0005}, 64'h00A3_00A2_00A1_00A0, 4);
        exp_burst(0, c + 16, {1'b0, 16'h0060}, pat4({1'b0, 16'h0060}), 4);
        wait_until(c + 16);
        i_req = 1'b0;
        d_req = 2'd0;
        wait_until(c + 20);

        // Illegal D request, then reset during beat 2 of an I read.
        c = cyc;
        d_req = 2'd3;
        exp_illegal(c + 1);
        wait_until(c + 1);
        d_req = 2'd0;
        chk("illegal_no_d_ack", 32'(d_ack), 32'd0);
        wait_until(c + 2);
        chk("illegal_one_cycle", 32'(illegal_req), 32'd0);
        c2 = cyc;
        i_addr = 16'h0012;
        i_req  = 1'b1;
        exp_burst(0, c2 + 1, {1'b0, 16'h0012}, pat4({1'b0, 16'h0012}), 3);
        wait_until(c2 + 1);
        i_req = 1'b0;
        wait_until(c2 + 3);
        n_rst = 1'b0;
        wait_until(c2 + 4);
        chk("abort_mem_en", 32'(mem_en), 32'd0);
        chk("abort_i_rvalid", 32'(i_rvalid), 32'd0);
        chk("abort_i_rdata", 32'(i_rdata), 32'd0);
        chk("abort_beat", 32'(beat), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        n_rst = 1'b1;
        wait_until(c2 + 8);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
